// File: rtl/adc_serial_mc_ctrl.sv
// Multi-channel controller for AD7960-class LVDS SAR ADCs: CNV/SCLK sequencing,
// fixed-delay capture of the returning data lines and a wide valid/ready result.
module adc_serial_mc_ctrl #(
  parameter int unsigned DATA_W   = 18,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CYC_W    = 16,
  parameter int unsigned TMSB_CNT = 20,
  parameter int unsigned CAP_DLY  = 3
) (
  input  logic                   fast_clk_i,
  input  logic                   reset_n_i,
  input  logic                   run_i,
  input  logic [CYC_W-1:0]       cyc_len_i,
  input  logic [CYC_W-1:0]       cnvh_len_i,
  input  logic [N_CH-1:0]        d_i,
  output logic                   cnv_o,
  output logic                   sclk_en_o,
  output logic [N_CH*DATA_W-1:0] data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   overrun_o,
  output logic [7:0]             ovr_cnt_o,
  output logic                   busy_o
);

  localparam int unsigned PW      = CYC_W + 1;
  localparam int unsigned FIX_LEN = TMSB_CNT + DATA_W + CAP_DLY + 2;

  typedef enum logic [2:0] {
    IDLE, CONV, WAIT_MSB, READ, DRAIN, LOAD
  } state_t;

  state_t             state, state_n;
  logic [CYC_W-1:0]   ph, ph_n;
  logic [PW-1:0]      cnt, cnt_n;
  logic [PW-1:0]      per, per_n;
  logic [CYC_W-1:0]   hi, hi_n;
  logic               pend, pend_n;
  logic               start_c;

  logic [CYC_W-1:0]   h_in;
  logic [PW-1:0]      p_min, p_in;

  logic               cnv_n, sclk_n, busy_n, valid_n, ovr_n;
  logic [CAP_DLY-1:0] dly;
  logic [DATA_W-1:0]  sr [N_CH];

  // Period is widened by one bit so the minimum-length clamp cannot wrap.
  always_comb begin
    h_in  = (cnvh_len_i == '0) ? CYC_W'(1) : cnvh_len_i;
    p_min = PW'(h_in) + PW'(FIX_LEN);
    p_in  = (PW'(cyc_len_i) > p_min) ? PW'(cyc_len_i) : p_min;
  end

  always_ff @(posedge fast_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      ph    <= '0;
      cnt   <= '0;
      per   <= '0;
      hi    <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      ph    <= ph_n;
      cnt   <= cnt_n;
      per   <= per_n;
      hi    <= hi_n;
      pend  <= pend_n;
    end
  end

  // pend marks the tail of a cycle after LOAD, still counting towards the boundary
  always_comb begin
    state_n = state;
    ph_n    = ph + CYC_W'(1);
    cnt_n   = cnt + PW'(1);
    per_n   = per;
    hi_n    = hi;
    pend_n  = pend;
    start_c = 1'b0;
    case (state)
      IDLE: begin
        ph_n = '0;
        if (pend) begin
          if (cnt == per) begin
            if (run_i) start_c = 1'b1;
            else       pend_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt;
          if (run_i) start_c = 1'b1;
        end
      end
      CONV: begin
        if (ph == hi - CYC_W'(1)) begin
          state_n = WAIT_MSB;
          ph_n    = '0;
        end
      end
      WAIT_MSB: begin
        if (ph == CYC_W'(TMSB_CNT - 1)) begin
          state_n = READ;
          ph_n    = '0;
        end
      end
      READ: begin
        if (ph == CYC_W'(DATA_W - 1)) begin
          state_n = DRAIN;
          ph_n    = '0;
        end
      end
      DRAIN: begin
        if (ph == CYC_W'(CAP_DLY - 1)) begin
          state_n = LOAD;
          ph_n    = '0;
        end
      end
      LOAD: begin
        state_n = IDLE;
        pend_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (start_c) begin
      state_n = CONV;
      ph_n    = '0;
      cnt_n   = '0;
      per_n   = p_in;
      hi_n    = h_in;
      pend_n  = 1'b0;
    end
  end

  // A handshake during LOAD consumes the old word, so the new one stays valid.
  always_comb begin
    cnv_n   = (state_n == CONV);
    sclk_n  = (state_n == READ);
    busy_n  = (state_n != IDLE);
    valid_n = valid_o & ~ready_i;
    ovr_n   = 1'b0;
    if (state == LOAD) begin
      valid_n = 1'b1;
      ovr_n   = valid_o & ~ready_i;
    end
  end

  always_ff @(posedge fast_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnv_o     <= 1'b0;
      sclk_en_o <= 1'b0;
      busy_o    <= 1'b0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
      ovr_cnt_o <= '0;
    end else begin
      cnv_o     <= cnv_n;
      sclk_en_o <= sclk_n;
      busy_o    <= busy_n;
      valid_o   <= valid_n;
      overrun_o <= ovr_n;
      if (ovr_n && (ovr_cnt_o != 8'hFF)) ovr_cnt_o <= ovr_cnt_o + 8'd1;
    end
  end

  // Delayed SCLK enable picks the clocks on which the round-tripped bits are valid.
  always_ff @(posedge fast_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      dly    <= '0;
      data_o <= '1;
      for (int k = 0; k < N_CH; k++) sr[k] <= '1;
    end else begin
      dly <= (dly << 1) | CAP_DLY'(sclk_en_o);
      for (int k = 0; k < N_CH; k++) begin
        if (start_c)                sr[k] <= '1;
        else if (dly[CAP_DLY-1])    sr[k] <= {sr[k][DATA_W-2:0], d_i[k]};
      end
      if (state == LOAD) begin
        for (int k = 0; k < N_CH; k++) data_o[k*DATA_W +: DATA_W] <= sr[k];
      end
    end
  end

endmodule
